// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a row of seven-segment digits.
// Host updates are staged in a pending buffer and committed only at frame end.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_mask,
  input  logic [NUM_DIGITS-1:0]   wr_blink,
  input  logic                    lzb_en,
  output logic [3:0]              dig_nibble,
  output logic                    dig_enable,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             pend_vld_q, pend_vld_d;
  disp_t            shadow_q, shadow_d;
  disp_t            pend_q, pend_d;

  logic                  frame_end;
  logic                  wr_fire;
  logic [NUM_DIGITS-1:0] lead_zero;

  assign frame_end = (div_cnt_q == DIV_LAST) && (idx_q == IDX_LAST);
  assign wr_ready  = !pend_vld_q;
  assign wr_fire   = wr_valid && !pend_vld_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
    div_cnt_d     = div_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    pend_vld_d    = pend_vld_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (frame_end) begin
      if (pend_vld_q) begin
        shadow_d   = pend_q;
        pend_vld_d = 1'b0;
      end
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A transfer needs pend_vld_q low, so it never collides with a commit.
    if (wr_fire) begin
      pend_d.data  = wr_data;
      pend_d.mask  = wr_mask;
      pend_d.blink = wr_blink;
      pend_vld_d   = 1'b1;
    end
  end

  // Digit i is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (shadow_q.data[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  // NOTE: the display buffers are reset along with the counters so reset always yields a blank display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_vld_q    <= 1'b0;
      shadow_q      <= '0;
      pend_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_vld_q    <= pend_vld_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
    end
  end

  assign frame_done = frame_end;
  assign an_n       = ~(NUM_DIGITS'(1) << idx_q);
  assign dig_nibble = shadow_q.data[4*idx_q +: 4];
  assign dig_enable = shadow_q.mask[idx_q]
                   && !(lzb_en && lead_zero[idx_q])
                   && !(shadow_q.blink[idx_q] && blink_phase_q);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a frame-level model feeds a per-digit scoreboard
// that is compared against the scan outputs on every cycle.
module tb_seg_scan_ctrl;

  localparam int ND    = 8;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic [7:0]  wr_blink = '0;
  logic        lzb_en = 1'b0;
  logic [3:0]  dig_nibble;
  logic        dig_enable;
  logic [7:0]  an_n;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .wr_blink   (wr_blink),
    .lzb_en     (lzb_en),
    .dig_nibble (dig_nibble),
    .dig_enable (dig_enable),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [7:0]  blink;
  } upd_t;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] nib;
    logic       en;
  } exp_t;

  exp_t sb[$];
  upd_t hq[$];
  int   h_start;
  bit   fire_q;

  upd_t m_shadow, m_pend;
  bit   m_pend_vld, m_phase;
  int   m_bcnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_shadow   = '0;
    m_pend     = '0;
    m_pend_vld = 1'b0;
    m_phase    = 1'b0;
    m_bcnt     = 0;
    fire_q     = 1'b0;
    h_start    = 0;
    wr_valid   = 1'b0;
    sb.delete();
    hq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " an_n"},       32'(an_n),       32'h0000_00FE);
    check({tag, " dig_nibble"}, 32'(dig_nibble), 32'h0);
    check({tag, " dig_enable"}, 32'(dig_enable), 32'h0);
    check({tag, " wr_ready"},   32'(wr_ready),   32'h1);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Expected scan of one whole frame, derived from the modelled shadow state.
  task automatic push_frame();
    for (int d = 0; d < ND; d++) begin
      exp_t        e;
      logic [31:0] upper;
      logic [7:0]  one_hot;
      bit          lz;
      upper   = m_shadow.data >> (4 * d);
      lz      = (d != 0) && (upper == 32'h0);
      one_hot = 8'h01 << d;
      e.an    = ~one_hot;
      e.nib   = m_shadow.data[4*d +: 4];
      e.en    = m_shadow.mask[d] && !(lzb_en && lz) && !(m_shadow.blink[d] && m_phase);
      sb.push_back(e);
    end
  endtask

  // Called at the negedge of a frame's first cycle; returns at the negedge n_cyc cycles later.
  task automatic run_frame(input int n_cyc = FRAME);
    exp_t cur;
    bit   fire;
    cur = '0;
    push_frame();
    for (int c = 0; c < n_cyc; c++) begin
      if (fire_q) begin
        void'(hq.pop_front());
        wr_valid = 1'b0;
        wr_data  = $urandom;
        wr_mask  = 8'($urandom);
        wr_blink = 8'($urandom);
        fire_q   = 1'b0;
      end
      if (c % SD == 0) cur = sb.pop_front();
      check($sformatf("an_n c%0d", c),       32'(an_n),       32'(cur.an));
      check($sformatf("dig_nibble c%0d", c), 32'(dig_nibble), 32'(cur.nib));
      check($sformatf("dig_enable c%0d", c), 32'(dig_enable), 32'(cur.en));
      check($sformatf("frame_done c%0d", c), 32'(frame_done), 32'(c == FRAME - 1));
      check($sformatf("wr_ready c%0d", c),   32'(wr_ready),   32'(!m_pend_vld));

      if (!wr_valid && hq.size() > 0 && c >= h_start) begin
        wr_valid = 1'b1;
        wr_data  = hq[0].data;
        wr_mask  = hq[0].mask;
        wr_blink = hq[0].blink;
        h_start  = 0;
      end
      fire = wr_valid && !m_pend_vld;

      if (c == FRAME - 1) begin
        if (m_pend_vld) begin
          m_shadow   = m_pend;
          m_pend_vld = 1'b0;
        end
        if (m_bcnt == BF - 1) begin
          m_bcnt  = 0;
          m_phase = !m_phase;
        end else begin
          m_bcnt++;
        end
      end
      if (fire) begin
        m_pend     = hq[0];
        m_pend_vld = 1'b1;
        fire_q     = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();

    // Reset and idle scanning.
    #1 rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame();
    run_frame();

    // Single write issued mid-frame: old frame stays blank, new value from next frame.
    hq.push_back('{data: 32'h1234_ABCD, mask: 8'hFF, blink: 8'h00});
    h_start = 9;
    run_frame();
    run_frame();

    // Back-to-back writes: second request held until the first commits.
    hq.push_back('{data: 32'hCAFE_0123, mask: 8'hFF, blink: 8'h00});
    hq.push_back('{data: 32'h0F1E_2D3C, mask: 8'h5A, blink: 8'h00});
    h_start = 3;
    run_frame();
    run_frame();
    run_frame();
    run_frame();

    // Leading-zero blanking on and off.
    lzb_en = 1'b1;
    hq.push_back('{data: 32'h0000_0050, mask: 8'hFF, blink: 8'h00});
    h_start = 0;
    run_frame();
    run_frame();
    lzb_en = 1'b0;
    run_frame();

    // Blink on digit 0 only.
    hq.push_back('{data: 32'h8765_4321, mask: 8'hFF, blink: 8'h01});
    h_start = 5;
    for (int f = 0; f < 6; f++) run_frame();

    // Reset asserted mid-frame with an update pending.
    hq.push_back('{data: 32'hDEAD_BEEF, mask: 8'hFF, blink: 8'h00});
    h_start = 6;
    run_frame(20);
    check("pending before reset", 32'(wr_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame();
    run_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
